// File: rtl/px_fill_engine.sv
// Rectangle fill engine: clips a fill command to the pixel plane and writes one
// RGB332 color into VRAM, one pixel per granted cycle, optionally frame-synced.
module px_fill_engine #(
    parameter int PLANE_W = 320,
    parameter int PLANE_H = 240,
    parameter int ADDR_W  = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [8:0]        cmd_x,
    input  logic [7:0]        cmd_y,
    input  logic [8:0]        cmd_w,
    input  logic [7:0]        cmd_h,
    input  logic [7:0]        cmd_color,
    input  logic              cmd_sync,
    input  logic              frameDrawn,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_d,
    output logic              vram_we,
    input  logic              vram_grant
);

    typedef enum logic [2:0] {IDLE, WAITFRAME, SETUP, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(PLANE_W);

    state_t            state;
    state_t            state_n;
    logic [8:0]        x_q;
    logic [7:0]        y_q;
    logic [8:0]        w_q;
    logic [7:0]        h_q;
    logic [7:0]        color_q;
    logic              fd_q;
    logic [8:0]        ew;
    logic [7:0]        eh;
    logic [8:0]        col;
    logic [7:0]        row;
    logic [ADDR_W-1:0] row_base;
    logic              setup_empty;
    logic              col_last;
    logic              row_last;

    function automatic logic [8:0] clip_w(input logic [8:0] x, input logic [8:0] w);
        logic [9:0] room;
        room = 10'(PLANE_W) - {1'b0, x};
        return ({1'b0, w} < room) ? w : room[8:0];
    endfunction

    function automatic logic [7:0] clip_h(input logic [7:0] y, input logic [7:0] h);
        logic [8:0] room;
        room = 9'(PLANE_H) - {1'b0, y};
        return ({1'b0, h} < room) ? h : room[7:0];
    endfunction

    assign setup_empty = ({1'b0, x_q} >= 10'(PLANE_W)) || ({1'b0, y_q} >= 9'(PLANE_H)) ||
                         (w_q == 9'd0) || (h_q == 8'd0);
    assign col_last    = (col == ew - 9'd1);
    assign row_last    = (row == eh - 8'd1);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:      if (start) state_n = cmd_sync ? WAITFRAME : SETUP;
            WAITFRAME: if (frameDrawn && !fd_q) state_n = SETUP;
            SETUP:     state_n = setup_empty ? DONE : WRITE;
            WRITE:     if (vram_grant && col_last && row_last) state_n = DONE;
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        vram_we   = 1'b0;
        vram_addr = '0;
        vram_d    = '0;
        if (state == WRITE) begin
            vram_we   = 1'b1;
            vram_addr = row_base + ADDR_W'(x_q) + ADDR_W'(col);
            vram_d    = color_q;
        end
    end

    // Command capture: only an idle engine accepts a new command.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            x_q     <= cmd_x;
            y_q     <= cmd_y;
            w_q     <= cmd_w;
            h_q     <= cmd_h;
            color_q <= cmd_color;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fd_q     <= 1'b0;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
        end else begin
            fd_q <= frameDrawn;
            case (state)
                SETUP: begin
                    ew       <= clip_w(x_q, w_q);
                    eh       <= clip_h(y_q, h_q);
                    row_base <= ADDR_W'({y_q, 8'd0}) + ADDR_W'({y_q, 6'd0});
                    col      <= '0;
                    row      <= '0;
                end
                WRITE: begin
                    // Nothing advances without a grant, so address and data stay put.
                    if (vram_grant) begin
                        if (!col_last) begin
                            col <= col + 9'd1;
                        end else begin
                            col      <= '0;
                            row      <= row + 8'd1;
                            row_base <= row_base + STRIDE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_px_fill_engine.sv
// Scoreboard bench for px_fill_engine: expected writes are queued by the stimulus
// thread and consumed by a negedge monitor whenever a write is granted.
module tb_px_fill_engine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [8:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [8:0]  cmd_w;
    logic [7:0]  cmd_h;
    logic [7:0]  cmd_color;
    logic        cmd_sync;
    logic        frameDrawn;
    logic        busy;
    logic        done;
    logic [16:0] vram_addr;
    logic [7:0]  vram_d;
    logic        vram_we;
    logic        vram_grant;

    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          gcnt = 0;
    bit          grant_mode = 1'b0;
    logic [24:0] exp_q[$];

    always #5 clk = ~clk;

    px_fill_engine #(.PLANE_W(320), .PLANE_H(240), .ADDR_W(17)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color), .cmd_sync(cmd_sync), .frameDrawn(frameDrawn),
        .busy(busy), .done(done), .vram_addr(vram_addr), .vram_d(vram_d),
        .vram_we(vram_we), .vram_grant(vram_grant)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_w(input int a, input logic [7:0] d);
        exp_q.push_back({17'(a), d});
    endtask

    task automatic push_basic(input logic [7:0] d);
        push_w(650, d); push_w(651, d); push_w(652, d);
        push_w(970, d); push_w(971, d); push_w(972, d);
    endtask

    task automatic issue(input logic [8:0] x, input logic [7:0] y, input logic [8:0] w,
                         input logic [7:0] h, input logic [7:0] c, input logic s);
        cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c; cmd_sync = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check(name, 32'(found), 32'd1);
        tick();
    endtask

    task automatic basic_fill(input string tag);
        push_basic(8'hE0);
        issue(9'd10, 8'd2, 9'd3, 8'd2, 8'hE0, 1'b0);
        for (int j = 1; j <= 8; j++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_we"}, 32'(vram_we), 32'((j >= 2 && j <= 7) ? 1 : 0));
            check({tag, "_done"}, 32'(done), 32'((j == 8) ? 1 : 0));
            tick();
        end
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Grant driver: always 1, or a 1,0,0 repeating pattern.
    initial begin
        vram_grant = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            gcnt++;
            vram_grant = grant_mode ? (gcnt % 3 == 0) : 1'b1;
        end
    end

    // Monitor: consumes expected writes and checks hold-during-stall.
    initial begin
        logic        pw;
        logic        pg;
        logic [16:0] pa;
        logic [7:0]  pd;
        logic [24:0] e;
        pw = 1'b0; pg = 1'b0; pa = '0; pd = '0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (vram_we) begin
                if (pw && !pg) begin
                    check("hold_addr", 32'(vram_addr), 32'(pa));
                    check("hold_data", 32'(vram_d), 32'(pd));
                end
                if (vram_grant) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_write: got addr %0d expected no write", vram_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_addr", 32'(vram_addr), 32'(e[24:8]));
                        check("write_data", 32'(vram_d), 32'(e[7:0]));
                    end
                end
            end
            pw = vram_we; pg = vram_grant; pa = vram_addr; pd = vram_d;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int dc;
        reset_n = 1'b0; start = 1'b0; frameDrawn = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0; cmd_sync = 1'b0;
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'(vram_we), 32'd0);
        check("rst_addr", 32'(vram_addr), 32'd0);
        check("rst_data", 32'(vram_d), 32'd0);
        reset_n = 1'b1;
        tick();

        basic_fill("basic");

        // Right/bottom clipping: 2 pixels survive
        push_w(76798, 8'h5A); push_w(76799, 8'h5A);
        issue(9'd318, 8'd239, 9'd5, 8'd4, 8'h5A, 1'b0);
        wait_done("clip_done");
        check("clip_pending", 32'(exp_q.size()), 32'd0);

        // Empty commands
        for (int t = 0; t < 3; t++) begin
            case (t)
                0: issue(9'd320, 8'd0, 9'd5, 8'd5, 8'h11, 1'b0);
                1: issue(9'd5, 8'd5, 9'd0, 8'd5, 8'h11, 1'b0);
                default: issue(9'd5, 8'd5, 9'd5, 8'd0, 8'h11, 1'b0);
            endcase
            check("empty_busy1", 32'(busy), 32'd1);
            check("empty_we1", 32'(vram_we), 32'd0);
            check("empty_done1", 32'(done), 32'd0);
            tick();
            check("empty_busy2", 32'(busy), 32'd1);
            check("empty_we2", 32'(vram_we), 32'd0);
            check("empty_done2", 32'(done), 32'd1);
            tick();
            check("empty_busy3", 32'(busy), 32'd0);
        end

        // Grant stalls with an ignored start mid-fill
        grant_mode = 1'b1;
        push_basic(8'h1C);
        issue(9'd10, 8'd2, 9'd3, 8'd2, 8'h1C, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        issue(9'd0, 8'd0, 9'd1, 8'd1, 8'hFF, 1'b0);
        wait_done("stall_done");
        check("stall_pending", 32'(exp_q.size()), 32'd0);
        check("stall_idle", 32'(busy), 32'd0);
        tick();
        check("stall_idle2", 32'(busy), 32'd0);
        grant_mode = 1'b0;
        tick();

        // Frame sync: level already high at start must not count
        frameDrawn = 1'b1;
        tick(); tick();
        push_basic(8'h03);
        issue(9'd10, 8'd2, 9'd3, 8'd2, 8'h03, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("sync_busy_hi", 32'(busy), 32'd1);
            check("sync_we_hi", 32'(vram_we), 32'd0);
            tick();
        end
        frameDrawn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("sync_we_lo", 32'(vram_we), 32'd0);
            tick();
        end
        frameDrawn = 1'b1;
        check("sync_we_m", 32'(vram_we), 32'd0);
        tick();
        check("sync_we_m1", 32'(vram_we), 32'd0);
        tick();
        check("sync_we_m2", 32'(vram_we), 32'd1);
        wait_done("sync_done");
        check("sync_pending", 32'(exp_q.size()), 32'd0);
        frameDrawn = 1'b0;
        tick();

        // Reset during the third write
        push_w(650, 8'hE0); push_w(651, 8'hE0); push_w(652, 8'hE0);
        issue(9'd10, 8'd2, 9'd3, 8'd2, 8'hE0, 1'b0);
        tick(); tick(); tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_we", 32'(vram_we), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_addr", 32'(vram_addr), 32'd0);
        dc = done_cnt;
        for (int i = 0; i < 10; i++) tick();
        check("mrst_no_done", 32'(done_cnt), 32'(dc));
        check("mrst_pending", 32'(exp_q.size()), 32'd0);

        basic_fill("after_rst");

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
